pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Interlock, forwarding and flush controller for the 5-stage SimpleRisc pipeline (IF, OF, EX, MA, RW).
//  Keeps a shadow scoreboard of the destination registers in flight in EX, MA and RW.
//  Generates the load-use stall, branch flush and EX-stage operand forwarding selects.
//  Counts stall and flush events for performance monitoring.
// PARAMETERS
//  REG_W  4   register-id width (16 architectural regs; ra = r15)
//  CNT_W  16  width of the saturating event counters
// PORTS
//  clk           in   1      single system clock, rising edge
//  reset         in   1      asynchronous, active-high reset
//  of_valid      in   1      OF stage holds a real instruction (not a bubble)
//  of_src1       in   REG_W  OF operand-1 register (rs1; ra for ret)
//  of_src1_used  in   1      of_src1 is read by the instruction
//  of_src2       in   REG_W  OF operand-2 register (rs2; rd for st)
//  of_src2_used  in   1      of_src2 is read (0 for immediate forms)
//  of_dst        in   REG_W  OF destination register (r15 for call)
//  of_wb         in   1      instruction writes the register file
//  of_is_ld      in   1      instruction is ld
//  branch_taken  in   1      EX resolved a taken branch or call/ret this cycle (is_Branch_Taken)
//  stall         out  1      hold PC and IF/OF latch; insert bubble into OF/EX
//  flush         out  1      squash IF/OF and OF/EX contents (predict-not-taken recovery)
//  fwd_a_sel     out  2      EX operand A source: 00 OF/EX latch, 01 EX/MA aluResult, 10 MA/RW result
//  fwd_b_sel     out  2      EX operand B source, same encoding
//  stall_count   out  CNT_W  number of stall cycles, saturating
//  flush_count   out  CNT_W  number of flush events, saturating
// BEHAVIOUR
//  State: three stage entries EX, MA, RW, each {valid, wb, is_ld, dst}. EX also holds {src1,src1_used,src2,src2_used}.
//  Reset (async, immediate): all valid bits 0; counters 0. Consequently stall=0, flush=0 and fwd_*_sel=00 while reset is high.
//  Load-use hazard (combinational): ld_use = of_valid & EX.valid & EX.wb & EX.is_ld &
//    ((of_src1_used & of_src1==EX.dst) | (of_src2_used & of_src2==EX.dst)).
//  flush = branch_taken. stall = ld_use & ~branch_taken (flush wins; the stalled instruction is squashed anyway).
//  Each rising edge, when not in reset:
//   - EX entry: if flush or stall, EX.valid<=0 (bubble); else EX <= OF inputs with valid=of_valid.
//   - MA <= EX and RW <= MA unconditionally; the back end never stalls.
//   - The branch in EX itself is not squashed; it advances to MA normally.
//  Forwarding (combinational from registered state), evaluated per EX source (A uses src1, B uses src2):
//   - sel=01 if EX.valid & src_used & MA.valid & MA.wb & ~MA.is_ld & MA.dst==src.
//   - else sel=10 if EX.valid & src_used & RW.valid & RW.wb & RW.dst==src.
//   - else 00. MA has priority over RW (younger producer wins).
//   - A load in MA is never forwarded; the load-use stall places it in RW when the consumer reaches EX.
//  No forwarding into OF. The register file is write-first, so an RW write and an OF read of the same register in one cycle return the new value.
//  No hardwired zero register; r0 hazards are handled like any other register.
//  Stall latency: exactly 1 bubble per load-use pair. Flush penalty: 2 squashed slots.
//  Counters: stall_count +1 on each cycle with stall=1; flush_count +1 on each cycle with flush=1.
//  Both saturate at all-ones (no wrap).
//  Reset asserted mid-operation clears all in-flight scoreboard state. No stale forward or stall is produced after reset deasserts.
// TESTING
//  1. add r1,r2,r3 then add r4,r1,r5 back-to-back -> no stall; next cycle fwd_a_sel=01.
//  2. add r1,.. ; nop ; sub r6,r7,r1 -> fwd_b_sel=10 when sub is in EX; stall never asserts.
//  3. ld r1,[r2] then add r4,r1,r1 -> stall=1 for exactly one cycle; then fwd_a_sel=fwd_b_sel=10; stall_count=1.
//  4. ld r1 then st r1,[r2] (of_src2=r1) -> stall one cycle. ld r1 then mov r4,#5 (srcs unused) -> no stall.
//  5. branch_taken=1 while ld_use also true -> flush=1, stall=0; EX bubble next cycle; flush_count=1.
//  6. Preload counter to all-ones via repeated stalls (CNT_W=4 build) -> stall_count holds 15.
//     Assert reset mid-stream -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// OF-stage instruction descriptor, branch resolution and hazard-control outputs for pipeline_hazard_ctrl.
// The pipeline front end drives the master side; the controller is the slave.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_W = 4,
   parameter int CNT_W = 16
);
   logic             of_valid;
   logic [REG_W-1:0] of_src1;
   logic             of_src1_used;
   logic [REG_W-1:0] of_src2;
   logic             of_src2_used;
   logic [REG_W-1:0] of_dst;
   logic             of_wb;
   logic             of_is_ld;
   logic             branch_taken;
   logic             stall;
   logic             flush;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output of_valid, of_src1, of_src1_used, of_src2, of_src2_used,
             of_dst, of_wb, of_is_ld, branch_taken,
      input  stall, flush, fwd_a_sel, fwd_b_sel, stall_count, flush_count
   );

   modport slave (
      input  of_valid, of_src1, of_src1_used, of_src2, of_src2_used,
             of_dst, of_wb, of_is_ld, branch_taken,
      output stall, flush, fwd_a_sel, fwd_b_sel, stall_count, flush_count
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use interlock, branch flush and EX forwarding selects for the 5-stage pipeline; outputs are
// combinational from OF inputs and the EX/MA/RW shadow scoreboard; the back end never stalls.
module pipeline_hazard_ctrl #(
   parameter int REG_W = 4,
   parameter int CNT_W = 16
) (
   input logic                  clk,
   input logic                  reset,
   pipeline_hazard_ctrl_if.slave hz
);
   typedef struct packed {
      logic             valid;
      logic             wb;
      logic             is_ld;
      logic [REG_W-1:0] dst;
   } stage_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   stage_t           ex_q, ma_q, rw_q;
   logic [REG_W-1:0] ex_src1, ex_src2;
   logic             ex_src1_used, ex_src2_used;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic             ld_use, stall_i, flush_i;
   logic [1:0]       fwd_a, fwd_b;

   // Loads in MA are excluded: their data only exists once they reach RW.
   function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_W-1:0] src,
                                          input logic ex_v, input stage_t ma, input stage_t rw);
      logic [1:0] sel;
      sel = 2'b00;
      if (ex_v && used && ma.valid && ma.wb && !ma.is_ld && (ma.dst == src))
         sel = 2'b01;
      else if (ex_v && used && rw.valid && rw.wb && (rw.dst == src))
         sel = 2'b10;
      return sel;
   endfunction

   always_comb begin
      ld_use = hz.of_valid && ex_q.valid && ex_q.wb && ex_q.is_ld &&
               ((hz.of_src1_used && (hz.of_src1 == ex_q.dst)) ||
                (hz.of_src2_used && (hz.of_src2 == ex_q.dst)));
      flush_i = hz.branch_taken && !reset;
      stall_i = ld_use && !hz.branch_taken && !reset;
      fwd_a   = fwd_sel(ex_src1_used, ex_src1, ex_q.valid, ma_q, rw_q);
      fwd_b   = fwd_sel(ex_src2_used, ex_src2, ex_q.valid, ma_q, rw_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q         <= '0;
         ma_q         <= '0;
         rw_q         <= '0;
         ex_src1      <= '0;
         ex_src2      <= '0;
         ex_src1_used <= 1'b0;
         ex_src2_used <= 1'b0;
      end else begin
         if (flush_i || stall_i) begin
            ex_q         <= '0;
            ex_src1_used <= 1'b0;
            ex_src2_used <= 1'b0;
         end else begin
            ex_q.valid   <= hz.of_valid;
            ex_q.wb      <= hz.of_wb;
            ex_q.is_ld   <= hz.of_is_ld;
            ex_q.dst     <= hz.of_dst;
            ex_src1      <= hz.of_src1;
            ex_src2      <= hz.of_src2;
            ex_src1_used <= hz.of_src1_used;
            ex_src2_used <= hz.of_src2_used;
         end
         ma_q <= ex_q;
         rw_q <= ma_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_i && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + CNT_ONE;
         if (flush_i && (flush_cnt != CNT_MAX))
            flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

   assign hz.stall       = stall_i;
   assign hz.flush       = flush_i;
   assign hz.fwd_a_sel   = fwd_a;
   assign hz.fwd_b_sel   = fwd_b;
   assign hz.stall_count = stall_cnt;
   assign hz.flush_count = flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: per-cycle expected outputs are queued when an
// instruction is presented in OF and compared at the following falling edge.
module tb_pipeline_hazard_ctrl;
   localparam int REG_W = 4;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic             v;
      logic [REG_W-1:0] s1;
      logic             s1u;
      logic [REG_W-1:0] s2;
      logic             s2u;
      logic [REG_W-1:0] d;
      logic             wb;
      logic             ld;
   } instr_t;

   typedef struct packed {
      logic       st;
      logic       fl;
      logic [1:0] fa;
      logic [1:0] fb;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   nchk = 0;
   int   nerr = 0;
   exp_t  exp_q[$];
   string tag_q[$];

   pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();
   pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .hz(hz));

   always #5 clk = ~clk;

   function automatic instr_t mk(input logic v, input int s1, input logic s1u, input int s2,
                                 input logic s2u, input int d, input logic wb, input logic ld);
      instr_t i;
      i.v = v; i.s1 = REG_W'(s1); i.s1u = s1u; i.s2 = REG_W'(s2); i.s2u = s2u;
      i.d = REG_W'(d); i.wb = wb; i.ld = ld;
      return i;
   endfunction

   function automatic instr_t alu(input int d, input int s1, input int s2);
      return mk(1'b1, s1, 1'b1, s2, 1'b1, d, 1'b1, 1'b0);
   endfunction

   function automatic instr_t nop();
      return mk(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      nchk++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input instr_t i, input logic br);
      hz.of_valid     = i.v;
      hz.of_src1      = i.s1;
      hz.of_src1_used = i.s1u;
      hz.of_src2      = i.s2;
      hz.of_src2_used = i.s2u;
      hz.of_dst       = i.d;
      hz.of_wb        = i.wb;
      hz.of_is_ld     = i.ld;
      hz.branch_taken = br;
   endtask

   // One pipeline cycle: present OF, queue expectation, compare off-edge, advance.
   task automatic step(input string tag, input instr_t i, input logic br, input logic st,
                       input logic fl, input logic [1:0] fa, input logic [1:0] fb);
      exp_t e;
      string t;
      drive(i, br);
      e.st = st; e.fl = fl; e.fa = fa; e.fb = fb;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".stall"}, 16'(hz.stall), 16'(e.st));
      check({t, ".flush"}, 16'(hz.flush), 16'(e.fl));
      check({t, ".fwd_a"}, 16'(hz.fwd_a_sel), 16'(e.fa));
      check({t, ".fwd_b"}, 16'(hz.fwd_b_sel), 16'(e.fb));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 3; k++) step("drain", nop(), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
   endtask

   initial begin
      reset = 1'b1;
      drive(nop(), 1'b1);
      #1;
      check("rst.flush", 16'(hz.flush), 16'd0);
      check("rst.stall", 16'(hz.stall), 16'd0);
      check("rst.fwd_a", 16'(hz.fwd_a_sel), 16'd0);
      check("rst.stall_count", 16'(hz.stall_count), 16'd0);
      drive(nop(), 1'b0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      step("idle", nop(), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

      // add r1,r2,r3 ; add r4,r1,r5
      step("t1.c1", alu(1, 2, 3), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("t1.c2", alu(4, 1, 5), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("t1.c3", nop(),        1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
      drain();

      // add r1,r2,r3 ; nop ; sub r6,r7,r1
      step("t2.c1", alu(1, 2, 3), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("t2.c2", nop(),        1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("t2.c3", alu(6, 7, 1), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("t2.c4", nop(),        1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
      drain();

      // ld r1,[r2] ; add r4,r1,r1 (held in OF during the stall)
      step("t3.c1", mk(1, 2, 1, 0, 0, 1, 1, 1), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("t3.c2", alu(4, 1, 1),               1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
      step("t3.c3", alu(4, 1, 1),               1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("t3.c4", nop(),                      1'b0, 1'b0, 1'b0, 2'b10, 2'b10);
      check("t3.stall_count", 16'(hz.stall_count), 16'd1);
      drain();

      // ld r1,[r2] ; st r1,[r2]
      step("t4a.c1", mk(1, 2, 1, 0, 0, 1, 1, 1), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("t4a.c2", mk(1, 2, 1, 1, 1, 0, 0, 0), 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
      step("t4a.c3", mk(1, 2, 1, 1, 1, 0, 0, 0), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("t4a.c4", nop(),                      1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
      drain();
      // ld r1,[r2] ; mov r4,#5 (source fields name r1 but are unused)
      step("t4b.c1", mk(1, 2, 1, 0, 0, 1, 1, 1), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("t4b.c2", mk(1, 1, 0, 1, 0, 4, 1, 0), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("t4b.c3", nop(),                      1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      check("t4.stall_count", 16'(hz.stall_count), 16'd2);
      drain();

      // ld r1 ; add r4,r1,r5 with taken branch ; add r6,r4,r4 must not see r4 forwarded
      step("t5.c1", mk(1, 2, 1, 0, 0, 1, 1, 1), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("t5.c2", alu(4, 1, 5),               1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
      step("t5.c3", alu(6, 4, 4),               1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      check("t5.flush_count", 16'(hz.flush_count), 16'd1);
      check("t5.stall_count", 16'(hz.stall_count), 16'd2);
      step("t5.c4", nop(),                      1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      drain();

      // Back-to-back ld r1,[r1]: stall every other cycle, later ones forwarded from RW.
      for (int i = 0; i < 35; i++) begin
         if (i % 2 == 1)
            step("t6.loop", mk(1, 1, 1, 0, 0, 1, 1, 1), 1'b0, 1'b1, 1'b0,
                 (i >= 3) ? 2'b10 : 2'b00, 2'b00);
         else
            step("t6.loop", mk(1, 1, 1, 0, 0, 1, 1, 1), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      end
      check("t6.stall_sat", 16'(hz.stall_count), 16'd15);
      check("t6.flush_hold", 16'(hz.flush_count), 16'd1);

      drive(mk(1, 1, 1, 0, 0, 1, 1, 1), 1'b1);
      #1;
      check("t6.pre.flush", 16'(hz.flush), 16'd1);
      check("t6.pre.stall", 16'(hz.stall), 16'd0);
      check("t6.pre.fwd_a", 16'(hz.fwd_a_sel), 16'd2);
      reset = 1'b1;
      #1;
      check("t6.rst.flush", 16'(hz.flush), 16'd0);
      check("t6.rst.stall", 16'(hz.stall), 16'd0);
      check("t6.rst.fwd_a", 16'(hz.fwd_a_sel), 16'd0);
      check("t6.rst.fwd_b", 16'(hz.fwd_b_sel), 16'd0);
      check("t6.rst.stall_count", 16'(hz.stall_count), 16'd0);
      check("t6.rst.flush_count", 16'(hz.flush_count), 16'd0);
      @(posedge clk); #1;
      drive(nop(), 1'b0);
      reset = 1'b0;
      step("t6.post.c1", alu(1, 1, 1), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("t6.post.c2", nop(),        1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      check("t6.post.stall_count", 16'(hz.stall_count), 16'd0);
      check("t6.post.flush_count", 16'(hz.flush_count), 16'd0);
      check("sb.empty", 16'(exp_q.size()), 16'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
